motor_pwm_driver: RTL and testbench

Dual-channel H-bridge PWM stage that sits directly downstream of MotorControl. It consumes the per-motor direction and 8-bit speed commands and produces the two H-bridge input pins per motor. Commands are applied only at PWM period boundaries, so no output pulse is ever truncated. A direction reversal inserts a dead-time interval with both bridge inputs low.

---
 rtl/motor_pwm_pkg.sv | 32 +++
 rtl/motor_pwm_channel.sv | 127 ++++++++++++
 rtl/motor_pwm_driver.sv | 99 +++++++++
 tb/tb_motor_pwm_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared types and constants for the dual-channel H-bridge PWM driver.
// Contents: channel state encoding, PWM counter limits, direction encoding,
// and the duty ramp helper used when MOTOR_PWM_RAMP_EN is defined.
package motor_pwm_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } chan_state_e;

    localparam int unsigned PWM_W = 8;

    localparam logic [PWM_W-1:0] PWM_MAX  = 8'd255;
    localparam logic [PWM_W-1:0] PWM_WRAP = 8'd254;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Move cur toward tgt by at most step, landing exactly on tgt.
    function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                     input logic [PWM_W-1:0] tgt,
                                                     input logic [PWM_W-1:0] step);
        logic [PWM_W-1:0] res;
        if (cur < tgt) begin
            res = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else begin
            res = ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: direction/duty FSM updated only at PWM period
// boundaries, dead-time on reversal, registered bridge outputs.
// Optional feature macro: MOTOR_PWM_RAMP_EN (duty slews by RAMP_STEP/period).
// Ports:
//   clk_in, reset_in   clock, asynchronous active-high reset
//   boundary           one-cycle strobe on the tick where pwm_cnt wraps to 0
//   pwm_cnt            shared PWM counter 0..254
//   cmd_dir, cmd_speed commanded direction (0 fwd, 1 rev) and duty
//   a_out, b_out       bridge inputs (A is PWM forward, B is PWM reverse)
module motor_pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int unsigned DEAD_PERIODS = 2
`ifdef MOTOR_PWM_RAMP_EN
    ,
    parameter int unsigned RAMP_STEP = 8
`endif
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       boundary,
    input  logic [7:0] pwm_cnt,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_speed,
    output logic       a_out,
    output logic       b_out
);

    localparam int unsigned DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DCW-1:0] DEAD_RELOAD = DCW'(DEAD_PERIODS - 1);
`ifdef MOTOR_PWM_RAMP_EN
    localparam logic [7:0] STEP = 8'(RAMP_STEP);
`endif

    chan_state_e    state_q, state_d;
    logic [7:0]     duty_q, duty_d;
    logic           dir_q, dir_d;
    logic [DCW-1:0] dead_q, dead_d;
    logic           a_q, a_d;
    logic           b_q, b_d;

    // State register, channel datapath and output flops.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_RUN;
            duty_q  <= '0;
            dir_q   <= DIR_FWD;
            dead_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state: commands are only looked at on a period boundary.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (boundary) begin
            unique case (state_q)
                ST_RUN: begin
                    if (cmd_dir == dir_q) begin
`ifdef MOTOR_PWM_RAMP_EN
                        duty_d = ramp_toward(duty_q, cmd_speed, STEP);
`else
                        duty_d = cmd_speed;
`endif
                    end else if (duty_q == 8'd0) begin
`ifdef MOTOR_PWM_RAMP_EN
                        // Ramped reversal: a full period at zero duty has
                        // elapsed, now hold both sides low for the dead time.
                        state_d = ST_DEAD;
                        dead_d  = DEAD_RELOAD;
`else
                        dir_d  = cmd_dir;
                        duty_d = cmd_speed;
`endif
                    end else begin
`ifdef MOTOR_PWM_RAMP_EN
                        duty_d = ramp_toward(duty_q, 8'd0, STEP);
`else
                        state_d = ST_DEAD;
                        duty_d  = 8'd0;
                        dead_d  = DEAD_RELOAD;
`endif
                    end
                end
                ST_DEAD: begin
                    if (dead_q != '0) begin
                        dead_d = dead_q - DCW'(1);
                    end else begin
                        state_d = ST_RUN;
                        dir_d   = cmd_dir;
`ifdef MOTOR_PWM_RAMP_EN
                        duty_d  = (cmd_speed < STEP) ? cmd_speed : STEP;
`else
                        duty_d  = cmd_speed;
`endif
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Output decode: PWM steered to one bridge side, both low in DEAD.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (state_q == ST_RUN && ((duty_q == PWM_MAX) || (pwm_cnt < duty_q))) begin
            a_d = (dir_q == DIR_FWD);
            b_d = (dir_q == DIR_REV);
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver. Owns the shared prescaler, PWM counter
// and period-start strobe; each motor is a motor_pwm_channel instance.
// Optional feature macro: MOTOR_PWM_RAMP_EN (adds RAMP_STEP parameter).
// Ports:
//   clk_in, reset_in                 clock, asynchronous active-high reset
//   m1/m2_direction_in, _speed_in    per-motor direction and 8-bit duty
//   m1/m2_a_out, m1/m2_b_out         bridge inputs per motor
//   period_start_out                 pulse on first cycle of each PWM period
module motor_pwm_driver
    import motor_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned DEAD_PERIODS = 2
`ifdef MOTOR_PWM_RAMP_EN
    ,
    parameter int unsigned RAMP_STEP    = 8
`endif
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       m1_direction_in,
    input  logic       m2_direction_in,
    input  logic [7:0] m1_speed_in,
    input  logic [7:0] m2_speed_in,
    output logic       m1_a_out,
    output logic       m1_b_out,
    output logic       m2_a_out,
    output logic       m2_b_out,
    output logic       period_start_out
);

    localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PSW-1:0] prescale_q, prescale_d;
    logic [7:0]     pwm_cnt_q, pwm_cnt_d;
    logic           period_start_q;
    logic           tick_c;
    logic           boundary_c;

    // Timebase: prescaler tick advances the 0..254 PWM counter.
    always_comb begin
        tick_c     = (prescale_q == PSW'(PRESCALE - 1));
        boundary_c = tick_c && (pwm_cnt_q == PWM_WRAP);
        prescale_d = tick_c ? '0 : (prescale_q + PSW'(1));
        pwm_cnt_d  = pwm_cnt_q;
        if (tick_c) begin
            pwm_cnt_d = boundary_c ? 8'd0 : (pwm_cnt_q + 8'd1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            prescale_q     <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= boundary_c;
        end
    end

    assign period_start_out = period_start_q;

    motor_pwm_channel #(
        .DEAD_PERIODS(DEAD_PERIODS)
`ifdef MOTOR_PWM_RAMP_EN
        ,
        .RAMP_STEP(RAMP_STEP)
`endif
    ) u_ch1 (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .boundary (boundary_c),
        .pwm_cnt  (pwm_cnt_q),
        .cmd_dir  (m1_direction_in),
        .cmd_speed(m1_speed_in),
        .a_out    (m1_a_out),
        .b_out    (m1_b_out)
    );

    motor_pwm_channel #(
        .DEAD_PERIODS(DEAD_PERIODS)
`ifdef MOTOR_PWM_RAMP_EN
        ,
        .RAMP_STEP(RAMP_STEP)
`endif
    ) u_ch2 (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .boundary (boundary_c),
        .pwm_cnt  (pwm_cnt_q),
        .cmd_dir  (m2_direction_in),
        .cmd_speed(m2_speed_in),
        .a_out    (m2_a_out),
        .b_out    (m2_b_out)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: period-level reference model checked every
// cycle, plus literal per-period high counts for the directed scenarios.
module tb_motor_pwm_driver;

    localparam int P   = 1;
    localparam int DP  = 2;
    localparam int PER = 255 * P;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       m1_direction_in, m2_direction_in;
    logic [7:0] m1_speed_in, m2_speed_in;
    logic       m1_a_out, m1_b_out, m2_a_out, m2_b_out, period_start_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    motor_pwm_driver #(.PRESCALE(P), .DEAD_PERIODS(DP)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .m1_direction_in (m1_direction_in),
        .m2_direction_in (m2_direction_in),
        .m1_speed_in     (m1_speed_in),
        .m2_speed_in     (m2_speed_in),
        .m1_a_out        (m1_a_out),
        .m1_b_out        (m1_b_out),
        .m2_a_out        (m2_a_out),
        .m2_b_out        (m2_b_out),
        .period_start_out(period_start_out)
    );

    // Reference model: per channel the direction, duty and number of
    // remaining quiet periods; time is a plain clock count since reset.
    int   t;
    int   mdir[2], mduty[2], mquiet[2];
    logic ea[2], eb[2];
    logic eps;

    task automatic apply_cmd(input int c, input int d, input int s);
        if (mquiet[c] > 0) begin
            mquiet[c]--;
            if (mquiet[c] == 0) begin
                mdir[c]  = d;
                mduty[c] = s;
            end
        end else if (d == mdir[c]) begin
            mduty[c] = s;
        end else if (mduty[c] == 0) begin
            mdir[c]  = d;
            mduty[c] = s;
        end else begin
            mquiet[c] = DP;
            mduty[c]  = 0;
        end
    endtask

    always @(posedge clk_in or posedge reset_in) begin
        int pos;
        if (reset_in) begin
            t   = 0;
            eps = 1'b0;
            for (int c = 0; c < 2; c++) begin
                mdir[c] = 0; mduty[c] = 0; mquiet[c] = 0;
                ea[c] = 1'b0; eb[c] = 1'b0;
            end
        end else begin
            pos = (t / P) % 255;
            for (int c = 0; c < 2; c++) begin
                ea[c] = (mquiet[c] == 0) && (mdir[c] == 0) && (pos < mduty[c]);
                eb[c] = (mquiet[c] == 0) && (mdir[c] == 1) && (pos < mduty[c]);
            end
            t++;
            eps = ((t % PER) == 0);
            if (eps) begin
                apply_cmd(0, int'(m1_direction_in), int'(m1_speed_in));
                apply_cmd(1, int'(m2_direction_in), int'(m2_speed_in));
            end
        end
    end

    // Every-cycle comparison against the model, plus the a/b exclusion rule.
    always @(negedge clk_in) begin
        if (!reset_in) begin
            checks++;
            if ({m1_a_out, m1_b_out, m2_a_out, m2_b_out, period_start_out} !==
                {ea[0], eb[0], ea[1], eb[1], eps}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0d a1b1a2b2ps got %b%b%b%b%b expected %b%b%b%b%b",
                         t, m1_a_out, m1_b_out, m2_a_out, m2_b_out, period_start_out,
                         ea[0], eb[0], ea[1], eb[1], eps);
            end
            checks++;
            if ((m1_a_out && m1_b_out) || (m2_a_out && m2_b_out)) begin
                errors++;
                $display("FAIL ab_exclusive t=%0d got m1=%b%b m2=%b%b required never both high",
                         t, m1_a_out, m1_b_out, m2_a_out, m2_b_out);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!period_start_out && n < 2 * PER + 4);
        if (!period_start_out) begin
            checks++;
            errors++;
            $display("FAIL wait_ps timeout got %0d cycles expected a pulse", n);
        end
    endtask

    // Count highs over the outputs of one whole period (cycles after the
    // period_start cycle up to and including the next period_start cycle).
    task automatic measure(input bit do_wait, input int chg_at, input int chg_spd,
                           output int a1, output int b1, output int a2, output int b2);
        int n;
        a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        if (do_wait) wait_ps(n);
        for (int i = 0; i < PER; i++) begin
            if (i == chg_at) m2_speed_in = 8'(chg_spd);
            @(negedge clk_in);
            a1 += int'(m1_a_out); b1 += int'(m1_b_out);
            a2 += int'(m2_a_out); b2 += int'(m2_b_out);
        end
    endtask

    initial begin
        int a1, b1, a2, b2, n, hi, r;
        reset_in = 1'b1;
        m1_direction_in = 1'b0; m2_direction_in = 1'b0;
        m1_speed_in = 8'd0;     m2_speed_in = 8'd0;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", int'({m1_a_out, m1_b_out, m2_a_out, m2_b_out, period_start_out}), 0);
        reset_in = 1'b0;

        // Forward 128/255 from the first boundary; m2 idle.
        m1_speed_in = 8'd128;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("fwd128_a1", a1, 128); check("fwd128_b1", b1, 0);
        check("m2_idle_a", a2, 0);   check("m2_idle_b", b2, 0);
        wait_ps(n);
        check("period_len", n, PER);

        m1_speed_in = 8'd255;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("full_on_p1", a1, 255);
        measure(0, -1, 0, a1, b1, a2, b2);
        check("full_on_p2", a1, 255);
        m1_speed_in = 8'd0;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("full_off", a1, 0);

        // Reversal from nonzero duty: two quiet periods, then B at 128.
        m1_speed_in = 8'd128;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("fwd128_again", a1, 128);
        m1_direction_in = 1'b1;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("dead1", a1 + b1, 0);
        measure(0, -1, 0, a1, b1, a2, b2);
        check("dead2", a1 + b1, 0);
        measure(0, -1, 0, a1, b1, a2, b2);
        check("rev128_a1", a1, 0); check("rev128_b1", b1, 128);

        // Mid-period speed change waits for the next boundary.
        m2_speed_in = 8'd64;
        measure(1, -1, 0, a1, b1, a2, b2);
        check("m2_64", a2, 64);
        measure(0, 30, 200, a1, b1, a2, b2);
        check("m2_change_ignored", a2, 64);
        measure(0, -1, 0, a1, b1, a2, b2);
        check("m2_200", a2, 200);

        // Asynchronous reset in the middle of a high pulse.
        repeat (50) @(negedge clk_in);
        check("pre_reset_m2a", int'(m2_a_out), 1);
        check("pre_reset_m1b", int'(m1_b_out), 1);
        #2 reset_in = 1'b1;
        #1 check("async_reset_outputs",
                 int'({m1_a_out, m1_b_out, m2_a_out, m2_b_out, period_start_out}), 0);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        n = 0; hi = 0;
        do begin
            @(negedge clk_in);
            n++;
            hi += int'(m1_a_out) + int'(m1_b_out) + int'(m2_a_out) + int'(m2_b_out);
        end while (!period_start_out && n < 2 * PER);
        check("len_after_reset", n, PER);
        check("idle_before_first_boundary", hi, 0);
        // Duty is 0 after reset, so the pending reverse command needs no dead time.
        measure(0, -1, 0, a1, b1, a2, b2);
        check("rev_from_rest_b1", b1, 128); check("rev_from_rest_a1", a1, 0);
        check("m2_after_reset", a2, 200);

        // Randomized commands, checked cycle by cycle against the model.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk_in);
            r = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                m1_direction_in = 1'($urandom_range(0, 1));
                m1_speed_in = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 254));
            end else begin
                m2_direction_in = 1'($urandom_range(0, 1));
                m2_speed_in = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 254));
            end
        end
        repeat (4 * PER) @(negedge clk_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
